// File: rtl/proj_to_affine_if.sv
// Request/response bundle for the projective-to-affine converter.
// The requester drives the master side and proj_to_affine sits on the slave side.
interface proj_to_affine_if #(
    parameter int DATA_W = 256
);
    logic              i_start;
    logic [DATA_W-1:0] i_x;
    logic [DATA_W-1:0] i_y;
    logic [DATA_W-1:0] i_z;
    logic [DATA_W-1:0] o_x;
    logic [DATA_W-1:0] o_y;
    logic              o_error;
    logic              o_finished;

    modport master (
        output i_start, i_x, i_y, i_z,
        input  o_x, o_y, o_error, o_finished
    );

    modport slave (
        input  i_start, i_x, i_y, i_z,
        output o_x, o_y, o_error, o_finished
    );
endinterface

// File: rtl/proj_to_affine.sv
// Projective (X,Y,Z) -> affine (X/Z, Y/Z) mod P using a binary extended-Euclid
// inverter followed by two bit-serial shift-add modular multipliers.
module proj_to_affine #(
    parameter int              DATA_W = 256,
    parameter logic [DATA_W-1:0] P    = 256'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffed
) (
    input  logic            i_clk,
    input  logic            i_rst,
    proj_to_affine_if.slave bus
);
    localparam int CNT_W = $clog2(DATA_W);

    typedef enum logic [1:0] {
        S_IDLE,
        S_INV,
        S_MUL,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [DATA_W-1:0] r_x;
    logic [DATA_W-1:0] r_y;
    logic [DATA_W-1:0] r_u;
    logic [DATA_W-1:0] r_v;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_inv;
    logic [DATA_W-1:0] r_accx;
    logic [DATA_W-1:0] r_accy;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_ox;
    logic [DATA_W-1:0] r_oy;
    logic              r_err;
    logic              r_fin;

    logic              w_u_one;
    logic              w_v_one;
    logic              w_inv_bit;
    logic [DATA_W-1:0] w_dblx;
    logic [DATA_W-1:0] w_dbly;
    logic [DATA_W-1:0] w_accx_nxt;
    logic [DATA_W-1:0] w_accy_nxt;

    // t/2 mod P: odd values are made even by adding P first (needs a carry bit).
    function automatic logic [DATA_W-1:0] f_half(input logic [DATA_W-1:0] t);
        logic [DATA_W:0] s;
        s = {1'b0, t};
        if (t[0])
            s = s + {1'b0, P};
        s = s >> 1;
        return s[DATA_W-1:0];
    endfunction

    function automatic logic [DATA_W-1:0] f_sub_mod(input logic [DATA_W-1:0] a,
                                                    input logic [DATA_W-1:0] b);
        logic [DATA_W:0] d;
        d = {1'b0, a} - {1'b0, b};
        if (a < b)
            d = d + {1'b0, P};
        return d[DATA_W-1:0];
    endfunction

    // Reduce a value known to be < 2P into [0, P).
    function automatic logic [DATA_W-1:0] f_red(input logic [DATA_W:0] s);
        logic [DATA_W:0] r;
        r = s;
        if (s >= {1'b0, P})
            r = s - {1'b0, P};
        return r[DATA_W-1:0];
    endfunction

    function automatic logic [DATA_W-1:0] f_dbl(input logic [DATA_W-1:0] acc);
        return f_red({acc, 1'b0});
    endfunction

    function automatic logic [DATA_W-1:0] f_add(input logic [DATA_W-1:0] acc,
                                                input logic [DATA_W-1:0] op);
        return f_red({1'b0, acc} + {1'b0, op});
    endfunction

    assign w_u_one    = (r_u == DATA_W'(1));
    assign w_v_one    = (r_v == DATA_W'(1));
    assign w_inv_bit  = r_inv[r_cnt];
    assign w_dblx     = f_dbl(r_accx);
    assign w_dbly     = f_dbl(r_accy);
    assign w_accx_nxt = w_inv_bit ? f_add(w_dblx, r_x) : w_dblx;
    assign w_accy_nxt = w_inv_bit ? f_add(w_dbly, r_y) : w_dbly;

    assign bus.o_x        = r_ox;
    assign bus.o_y        = r_oy;
    assign bus.o_error    = r_err;
    assign bus.o_finished = r_fin;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.i_start)
                    w_state_nxt = (bus.i_z == '0) ? S_DONE : S_INV;
            end
            S_INV: begin
                if (w_u_one || w_v_one)
                    w_state_nxt = S_MUL;
            end
            S_MUL: begin
                if (r_cnt == '0)
                    w_state_nxt = S_DONE;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_x    <= '0;
            r_y    <= '0;
            r_u    <= '0;
            r_v    <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_inv  <= '0;
            r_accx <= '0;
            r_accy <= '0;
            r_cnt  <= '0;
            r_ox   <= '0;
            r_oy   <= '0;
            r_err  <= 1'b0;
            r_fin  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.i_start) begin
                        r_x <= bus.i_x;
                        r_y <= bus.i_y;
                        if (bus.i_z == '0) begin
                            r_err <= 1'b1;
                            r_ox  <= '0;
                            r_oy  <= '0;
                            r_fin <= 1'b1;
                        end else begin
                            r_u <= bus.i_z;
                            r_v <= P;
                            r_a <= DATA_W'(1);
                            r_b <= '0;
                        end
                    end
                end
                // Invariants a*Z == u and b*Z == v (mod P) hold across every step.
                S_INV: begin
                    if (w_u_one || w_v_one) begin
                        r_inv  <= w_u_one ? r_a : r_b;
                        r_accx <= '0;
                        r_accy <= '0;
                        r_cnt  <= CNT_W'(DATA_W - 1);
                    end else if (!r_u[0]) begin
                        r_u <= r_u >> 1;
                        r_a <= f_half(r_a);
                    end else if (!r_v[0]) begin
                        r_v <= r_v >> 1;
                        r_b <= f_half(r_b);
                    end else if (r_u >= r_v) begin
                        r_u <= (r_u - r_v) >> 1;
                        r_a <= f_half(f_sub_mod(r_a, r_b));
                    end else begin
                        r_v <= (r_v - r_u) >> 1;
                        r_b <= f_half(f_sub_mod(r_b, r_a));
                    end
                end
                // MSB-first double-and-add over the inverse, both coordinates in parallel.
                S_MUL: begin
                    r_accx <= w_accx_nxt;
                    r_accy <= w_accy_nxt;
                    r_cnt  <= r_cnt - 1'b1;
                    if (r_cnt == '0) begin
                        r_ox  <= w_accx_nxt;
                        r_oy  <= w_accy_nxt;
                        r_err <= 1'b0;
                        r_fin <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_fin <= 1'b0;
                end
                default: begin
                    r_fin <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_proj_to_affine.sv
// Self-checking bench for proj_to_affine: directed corner cases plus random points
// checked against plain modular arithmetic (o * Z mod P must give back the input).
`timescale 1ns/1ps
module tb_proj_to_affine;
    localparam logic [255:0] P = 256'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffed;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;
    int   fin_cnt;

    proj_to_affine_if #(.DATA_W(256)) bus();

    proj_to_affine #(.DATA_W(256), .P(P)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] mulmod(input logic [255:0] a, input logic [255:0] b);
        logic [511:0] prod;
        logic [511:0] rem;
        prod = {256'b0, a} * {256'b0, b};
        rem  = prod % {256'b0, P};
        return rem[255:0];
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++)
            r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (bus.o_finished)
                fin_cnt++;
        end
    endtask

    // Start at the next clock edge (cycle 0) and report the cycle in which o_finished is seen.
    task automatic run_op(input logic [255:0] x, input logic [255:0] y, input logic [255:0] z,
                          output int lat, output logic [255:0] ox, output logic [255:0] oy,
                          output logic err);
        @(negedge clk);
        bus.i_x     = x;
        bus.i_y     = y;
        bus.i_z     = z;
        bus.i_start = 1'b1;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        lat = 1;
        while (!bus.o_finished && lat < 800) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_val("finished_seen", bus.o_finished, 1);
        ox  = bus.o_x;
        oy  = bus.o_y;
        err = bus.o_error;
        @(posedge clk);
        #1;
        check_val("pulse_one_cycle", bus.o_finished, 0);
    endtask

    initial begin
        int           lat;
        logic [255:0] ox, oy, x, y, z;
        logic         err;

        n_cmp       = 0;
        n_bad       = 0;
        fin_cnt     = 0;
        rst         = 1'b1;
        bus.i_start = 1'b0;
        bus.i_x     = '0;
        bus.i_y     = '0;
        bus.i_z     = '0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_x", bus.o_x, 0);
        check_val("rst_y", bus.o_y, 0);
        check_val("rst_err", bus.o_error, 0);
        check_val("rst_fin", bus.o_finished, 0);
        @(negedge clk);
        rst = 1'b0;

        run_op(256'd6, 256'd9, 256'd3, lat, ox, oy, err);
        check_val("small_x", ox, 2);
        check_val("small_y", oy, 3);
        check_val("small_err", err, 0);
        check_val("small_lat_le768", lat <= 768, 1);

        x = 256'd7075909580202862594128302673554914659407030209928197693208324339654829354926;
        y = 256'd21286769175881002626746167682496214460774588269525023793279114113306181287586;
        run_op(x, y, 256'd1, lat, ox, oy, err);
        check_val("z1_x", ox, x);
        check_val("z1_y", oy, y);
        check_val("z1_err", err, 0);
        check_val("z1_lat", lat, 258);

        run_op(256'd5, 256'd7, P - 256'd1, lat, ox, oy, err);
        check_val("zm1_x", ox, P - 256'd5);
        check_val("zm1_y", oy, P - 256'd7);
        check_val("zm1_lat_le768", lat <= 768, 1);

        run_op(256'd1, 256'd1, 256'd0, lat, ox, oy, err);
        check_val("z0_err", err, 1);
        check_val("z0_x", ox, 0);
        check_val("z0_y", oy, 0);
        check_val("z0_lat", lat, 1);
        run_op(256'd6, 256'd9, 256'd3, lat, ox, oy, err);
        check_val("b2b_err", err, 0);
        check_val("b2b_x", ox, 2);
        check_val("b2b_y", oy, 3);

        // Busy pulses carry Z=0 so an accepted one would produce an early error pulse.
        @(negedge clk);
        bus.i_x = 256'd11; bus.i_y = 256'd13; bus.i_z = 256'd1; bus.i_start = 1'b1;
        @(posedge clk);
        #1;
        bus.i_x = 256'd99; bus.i_z = 256'd0;
        fin_cnt = 0;
        wait_cycles(1);
        bus.i_start = 1'b0;
        wait_cycles(98);
        bus.i_start = 1'b1;
        wait_cycles(1);
        bus.i_start = 1'b0;
        wait_cycles(49);
        check_val("busy_no_finish", fin_cnt, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_val("midrst_x", bus.o_x, 0);
        check_val("midrst_y", bus.o_y, 0);
        check_val("midrst_err", bus.o_error, 0);
        check_val("midrst_fin", bus.o_finished, 0);
        @(negedge clk);
        rst = 1'b0;
        fin_cnt = 0;
        wait_cycles(300);
        check_val("post_rst_idle", fin_cnt, 0);
        check_val("post_rst_x", bus.o_x, 0);
        run_op(256'd4, 256'd8, 256'd2, lat, ox, oy, err);
        check_val("fresh_x", ox, 2);
        check_val("fresh_y", oy, 4);
        check_val("fresh_err", err, 0);

        for (int t = 0; t < 100; t++) begin
            z = rand256() % (P - 256'd1) + 256'd1;
            x = rand256() % P;
            y = rand256() % P;
            run_op(x, y, z, lat, ox, oy, err);
            check_val("rnd_x_times_z", mulmod(ox, z), x);
            check_val("rnd_y_times_z", mulmod(oy, z), y);
            check_val("rnd_x_lt_p", ox < P, 1);
            check_val("rnd_y_lt_p", oy < P, 1);
            check_val("rnd_err", err, 0);
            check_val("rnd_lat_range", (lat >= 258) && (lat <= 768), 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
